// File: rtl/vm1_pwr_seq_pkg.sv
// Shared types for the VM1 power sequencer: state encoding and output decode.
package vm1_pwr_seq_pkg;

   typedef enum logic [2:0] {
      S_WAIT_LOCK = 3'd0,
      S_DCLO      = 3'd1,
      S_ACLO      = 3'd2,
      S_RUN       = 3'd3,
      S_PFAIL     = 3'd4
   } state_t;

   typedef struct packed {
      logic dclo;
      logic aclo;
      logic ready;
   } pwr_out_t;

   localparam pwr_out_t OUT_RESET = '{dclo: 1'b1, aclo: 1'b1, ready: 1'b0};
   localparam pwr_out_t OUT_ACLO  = '{dclo: 1'b0, aclo: 1'b1, ready: 1'b0};
   localparam pwr_out_t OUT_RUN   = '{dclo: 1'b0, aclo: 1'b0, ready: 1'b1};

   // Moore decode; DCLO only ever drops together with or before ACLO.
   function automatic pwr_out_t decode_out(input state_t st);
      pwr_out_t o;
      case (st)
         S_ACLO, S_PFAIL: o = OUT_ACLO;
         S_RUN:           o = OUT_RUN;
         default:         o = OUT_RESET;
      endcase
      return o;
   endfunction

   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/vm1_sync_deb.sv
// 2-FF synchroniser with optional stability debounce (DEB_CYCLES=0 bypasses it).
module vm1_sync_deb #(
   parameter int unsigned DEB_CYCLES = 0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic dout
);

   logic [1:0] sync;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync <= '0;
      else        sync <= {sync[0], din};
   end

   generate
      if (DEB_CYCLES == 0) begin : g_bypass
         assign dout = sync[1];
      end else begin : g_deb
         localparam int unsigned DW = $clog2(DEB_CYCLES + 1);
         logic [DW-1:0] cnt;
         logic          level;

         // Level follows the input only after DEB_CYCLES consecutive differing samples.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               cnt   <= '0;
               level <= 1'b1;
            end else if (sync[1] == level) begin
               cnt <= '0;
            end else if (32'(cnt) + 32'd1 >= DEB_CYCLES) begin
               cnt   <= '0;
               level <= sync[1];
            end else begin
               cnt <= cnt + DW'(1);
            end
         end

         assign dout = level;
      end
   endgenerate

endmodule

// File: rtl/vm1_pwr_seq.sv
// K1801VM1 DCLO/ACLO power-up and power-fail sequencer, gated by clock-generator lock.
module vm1_pwr_seq
   import vm1_pwr_seq_pkg::*;
#(
   parameter int unsigned LOCK_CYCLES = 1024,
   parameter int unsigned DCLO_CYCLES = 4096,
   parameter int unsigned ACLO_CYCLES = 2048,
   parameter int unsigned DEB_CYCLES  = 65536
) (
   input  logic CLK,
   input  logic RST_n,
   input  logic LOCK_IN,
   input  logic BTN_n,
   input  logic PWR_FAIL,
   output logic DCLO,
   output logic ACLO,
   output logic SYS_RST,
   output logic READY
);

   localparam int unsigned CNT_MAX = max3(LOCK_CYCLES, DCLO_CYCLES, ACLO_CYCLES);
   localparam int unsigned CW      = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] DCLO_LOAD = CW'(DCLO_CYCLES - 1);
   localparam logic [CW-1:0] ACLO_LOAD = CW'(ACLO_CYCLES - 1);

   logic          lock_s;
   logic          btn_deb;
   logic          btn_deb_q;
   logic          pf_s;
   logic          press_c;
   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   pwr_out_t      outs;

   vm1_sync_deb #(.DEB_CYCLES(0)) u_lock_sync (
      .clk(CLK), .rst_n(RST_n), .din(LOCK_IN), .dout(lock_s)
   );

   vm1_sync_deb #(.DEB_CYCLES(DEB_CYCLES)) u_btn_deb (
      .clk(CLK), .rst_n(RST_n), .din(BTN_n), .dout(btn_deb)
   );

   vm1_sync_deb #(.DEB_CYCLES(0)) u_pf_sync (
      .clk(CLK), .rst_n(RST_n), .din(PWR_FAIL), .dout(pf_s)
   );

   assign press_c = btn_deb_q & ~btn_deb;

   // Next state and shared lock/dwell counter; loss of lock overrides everything.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      if (state != S_WAIT_LOCK && !lock_s) begin
         state_n = S_WAIT_LOCK;
         cnt_n   = '0;
      end else begin
         case (state)
            S_WAIT_LOCK: begin
               if (!lock_s) begin
                  cnt_n = '0;
               end else if (32'(cnt) + 32'd1 >= LOCK_CYCLES) begin
                  state_n = S_DCLO;
                  cnt_n   = DCLO_LOAD;
               end else begin
                  cnt_n = cnt + CW'(1);
               end
            end
            S_DCLO: begin
               if (cnt != '0) begin
                  cnt_n = cnt - CW'(1);
               end else if (btn_deb && !pf_s) begin
                  state_n = S_ACLO;
                  cnt_n   = ACLO_LOAD;
               end
            end
            S_ACLO: begin
               // CPU is not running yet, so no power-fail window is needed.
               if (press_c || pf_s) begin
                  state_n = S_DCLO;
                  cnt_n   = DCLO_LOAD;
               end else if (cnt == '0) begin
                  state_n = S_RUN;
               end else begin
                  cnt_n = cnt - CW'(1);
               end
            end
            S_RUN: begin
               if (press_c || pf_s) begin
                  state_n = S_PFAIL;
                  cnt_n   = ACLO_LOAD;
               end
            end
            S_PFAIL: begin
               if (cnt == '0) begin
                  state_n = S_DCLO;
                  cnt_n   = DCLO_LOAD;
               end else begin
                  cnt_n = cnt - CW'(1);
               end
            end
            default: begin
               state_n = S_WAIT_LOCK;
               cnt_n   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         state     <= S_WAIT_LOCK;
         cnt       <= '0;
         outs      <= OUT_RESET;
         btn_deb_q <= 1'b1;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         outs      <= decode_out(state_n);
         btn_deb_q <= btn_deb;
      end
   end

   assign DCLO    = outs.dclo;
   assign ACLO    = outs.aclo;
   assign SYS_RST = outs.dclo;
   assign READY   = outs.ready;

endmodule

// File: tb/tb_vm1_pwr_seq.sv
// Scoreboard bench for vm1_pwr_seq: expected outputs are queued per edge number after reset release.
module tb_vm1_pwr_seq;

   localparam int unsigned LOCK_N = 4;
   localparam int unsigned DCLO_N = 8;
   localparam int unsigned ACLO_N = 6;
   localparam int unsigned DEB_N  = 3;

   typedef struct {
      int    cyc;
      logic  dclo;
      logic  aclo;
      logic  ready;
      string tag;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   logic lock_in = 1'b0;
   logic btn_n = 1'b1;
   logic pwr_fail = 1'b0;
   logic dclo, aclo, sys_rst, ready;

   int   cyc;
   int   n_checks = 0;
   int   n_pass   = 0;
   exp_t sb[$];

   vm1_pwr_seq #(
      .LOCK_CYCLES(LOCK_N),
      .DCLO_CYCLES(DCLO_N),
      .ACLO_CYCLES(ACLO_N),
      .DEB_CYCLES (DEB_N)
   ) dut (
      .CLK     (clk),
      .RST_n   (rst_n),
      .LOCK_IN (lock_in),
      .BTN_n   (btn_n),
      .PWR_FAIL(pwr_fail),
      .DCLO    (dclo),
      .ACLO    (aclo),
      .SYS_RST (sys_rst),
      .READY   (ready)
   );

   always #5 clk = ~clk;

   // Edge number since reset release: the first rising edge after release is 1.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, want, cyc);
   endtask

   task automatic push_exp(input int c, input logic d, input logic a, input logic r,
                           input string tag);
      exp_t e;
      e.cyc   = c;
      e.dclo  = d;
      e.aclo  = a;
      e.ready = r;
      e.tag   = tag;
      sb.push_back(e);
   endtask

   always @(negedge clk) begin : mon
      exp_t e;
      if (rst_n === 1'b1) begin
         while (sb.size() > 0 && sb[0].cyc < cyc) begin
            chk({sb[0].tag, "_missed"}, 32'(cyc), 32'(sb[0].cyc));
            void'(sb.pop_front());
         end
         if (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            chk({e.tag, "_dclo"},    32'(dclo),    32'(e.dclo));
            chk({e.tag, "_aclo"},    32'(aclo),    32'(e.aclo));
            chk({e.tag, "_ready"},   32'(ready),   32'(e.ready));
            chk({e.tag, "_sys_rst"}, 32'(sys_rst), 32'(e.dclo));
         end
      end
   end

   task automatic wait_to(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 200 && sb.size() > 0; i++) @(negedge clk);
      if (sb.size() != 0) begin
         chk({tag, "_timeout"}, 32'(sb.size()), 32'd0);
         sb.delete();
      end
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_dclo"},    32'(dclo),    32'd1);
      chk({tag, "_aclo"},    32'(aclo),    32'd1);
      chk({tag, "_sys_rst"}, 32'(sys_rst), 32'd1);
      chk({tag, "_ready"},   32'(ready),   32'd0);
   endtask

   // Reset, then release with LOCK_IN rising at edge 0.
   task automatic start_seq();
      rst_n    = 1'b0;
      lock_in  = 1'b0;
      btn_n    = 1'b1;
      pwr_fail = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset_outs("rst");
      rst_n   = 1'b1;
      lock_in = 1'b1;
   endtask

   task automatic power_up();
      start_seq();
      push_exp(20, 1'b0, 1'b0, 1'b1, "pu_run");
      wait_to(20);
   endtask

   initial begin
      // Power-up: DCLO entered at 6, DCLO falls at 14, RUN at 20.
      start_seq();
      push_exp(5,  1'b1, 1'b1, 1'b0, "a_wait");
      push_exp(13, 1'b1, 1'b1, 1'b0, "a_dclo");
      push_exp(14, 1'b0, 1'b1, 1'b0, "a_aclo");
      push_exp(19, 1'b0, 1'b1, 1'b0, "a_aclo_end");
      push_exp(20, 1'b0, 1'b0, 1'b1, "a_run");
      drain("a");

      // Lock glitch at count 3 delays everything by 4; then lock loss in RUN.
      start_seq();
      wait_to(3);
      lock_in = 1'b0;
      wait_to(4);
      lock_in = 1'b1;
      push_exp(14, 1'b1, 1'b1, 1'b0, "b_dclo_held");
      push_exp(17, 1'b1, 1'b1, 1'b0, "b_dclo");
      push_exp(18, 1'b0, 1'b1, 1'b0, "b_aclo");
      push_exp(23, 1'b0, 1'b1, 1'b0, "b_aclo_end");
      push_exp(24, 1'b0, 1'b0, 1'b1, "b_run");
      push_exp(28, 1'b0, 1'b0, 1'b1, "b_run_pre_loss");
      push_exp(29, 1'b1, 1'b1, 1'b0, "b_lock_loss");
      push_exp(43, 1'b1, 1'b1, 1'b0, "b_relock_dclo");
      push_exp(44, 1'b0, 1'b1, 1'b0, "b_relock_aclo");
      push_exp(50, 1'b0, 1'b0, 1'b1, "b_relock_run");
      wait_to(26);
      lock_in = 1'b0;
      wait_to(30);
      lock_in = 1'b1;
      drain("b");

      // Button: 2-clock bounce ignored, 5-clock press gives PFAIL window then DCLO.
      power_up();
      push_exp(30, 1'b0, 1'b0, 1'b1, "c_bounce");
      push_exp(37, 1'b0, 1'b0, 1'b1, "c_pre_press");
      push_exp(38, 1'b0, 1'b1, 1'b0, "c_pfail");
      push_exp(43, 1'b0, 1'b1, 1'b0, "c_pfail_end");
      push_exp(44, 1'b1, 1'b1, 1'b0, "c_dclo");
      push_exp(51, 1'b1, 1'b1, 1'b0, "c_dclo_end");
      push_exp(52, 1'b0, 1'b1, 1'b0, "c_aclo");
      push_exp(57, 1'b0, 1'b1, 1'b0, "c_aclo_end");
      push_exp(58, 1'b0, 1'b0, 1'b1, "c_run");
      wait_to(22);
      btn_n = 1'b0;
      wait_to(24);
      btn_n = 1'b1;
      wait_to(32);
      btn_n = 1'b0;
      wait_to(37);
      btn_n = 1'b1;
      drain("c");

      // PWR_FAIL held through PFAIL: DCLO held until the synchronised drop.
      power_up();
      push_exp(24, 1'b0, 1'b0, 1'b1, "d_run");
      push_exp(25, 1'b0, 1'b1, 1'b0, "d_pfail");
      push_exp(30, 1'b0, 1'b1, 1'b0, "d_pfail_end");
      push_exp(31, 1'b1, 1'b1, 1'b0, "d_dclo");
      push_exp(47, 1'b1, 1'b1, 1'b0, "d_dclo_hold");
      push_exp(48, 1'b0, 1'b1, 1'b0, "d_aclo");
      push_exp(53, 1'b0, 1'b1, 1'b0, "d_aclo_end");
      push_exp(54, 1'b0, 1'b0, 1'b1, "d_run2");
      wait_to(22);
      pwr_fail = 1'b1;
      wait_to(45);
      pwr_fail = 1'b0;
      drain("d");

      // PWR_FAIL pulse in S_ACLO: straight back to DCLO, full replay.
      start_seq();
      push_exp(17, 1'b0, 1'b1, 1'b0, "e_aclo");
      push_exp(18, 1'b1, 1'b1, 1'b0, "e_dclo");
      push_exp(25, 1'b1, 1'b1, 1'b0, "e_dclo_end");
      push_exp(26, 1'b0, 1'b1, 1'b0, "e_aclo2");
      push_exp(31, 1'b0, 1'b1, 1'b0, "e_aclo2_end");
      push_exp(32, 1'b0, 1'b0, 1'b1, "e_run");
      wait_to(15);
      pwr_fail = 1'b1;
      wait_to(16);
      pwr_fail = 1'b0;
      drain("e");

      // Asynchronous reset in S_ACLO, then a clean restart.
      start_seq();
      push_exp(16, 1'b0, 1'b1, 1'b0, "f_aclo");
      wait_to(16);
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_outs("f_async");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      push_exp(5,  1'b1, 1'b1, 1'b0, "f_wait");
      push_exp(14, 1'b0, 1'b1, 1'b0, "f_aclo2");
      push_exp(20, 1'b0, 1'b0, 1'b1, "f_run");
      drain("f");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
